// File: rtl/demux_pkg.sv
// Shared lane count, select width and lane-select type for the 1-to-8 demux.
package demux_pkg;
    localparam int NUM_LANES = 8;
    localparam int SEL_W     = 3;
    typedef logic [SEL_W-1:0] lane_sel_t;
endpackage

// File: rtl/demux_lane.sv
// One output lane: a single-entry register with its own valid/ready handshake.
// A load in the same cycle as a drain wins, so a continuously ready consumer
// sees one word per cycle.
module demux_lane #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         load,
    input  logic [N-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [N-1:0] dout
);

    // valid: flush beats everything, then load, then drain
    always_ff @(posedge clk) begin
        if (rst)
            valid <= 1'b0;
        else if (flush)
            valid <= 1'b0;
        else if (load)
            valid <= 1'b1;
        else if (valid && ready)
            valid <= 1'b0;
    end

    // data only changes on load; it is kept across drain and flush
    always_ff @(posedge clk) begin
        if (rst)
            dout <= '0;
        else if (load)
            dout <= din;
    end

endmodule

// File: rtl/demux128_reg.sv
// Registered 1-to-8 demultiplexer: steers one accepted word per cycle into one
// of eight single-entry lane registers and counts accepted words (saturating).
// Build option DEMUX_AUTO_SEL_EN: ignore in_sel and pick lanes with an internal
// round-robin pointer that advances on every accepted word.
module demux128_reg
    import demux_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_data,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 flush,
    output logic [N-1:0]         out_data [NUM_LANES-1:0],
    output logic [NUM_LANES-1:0] out_valid,
    input  logic [NUM_LANES-1:0] out_ready,
    output logic [CNT_W-1:0]     acc_cnt
);

    lane_sel_t              s;
    logic                   xfer;
    logic [NUM_LANES-1:0]   load;

`ifdef DEMUX_AUTO_SEL_EN
    lane_sel_t ptr;
    wire unused_sel = ^in_sel;

    // round-robin pointer: steps on each accepted word, untouched by flush
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (xfer)
            ptr <= lane_sel_t'(ptr + 1'b1);
    end

    assign s = ptr;
`else
    assign s = in_sel;
`endif

    // the destination lane can take a word if it is empty or draining now
    assign in_ready = ~flush & (~out_valid[s] | out_ready[s]);
    assign xfer     = in_valid & in_ready;

    // one-hot load strobe toward the selected lane
    always_comb begin
        load    = '0;
        load[s] = xfer;
    end

    // accepted-word counter, sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst)
            acc_cnt <= '0;
        else if (xfer && (acc_cnt != '1))
            acc_cnt <= acc_cnt + CNT_W'(1);
    end

    genvar k;
    generate
        for (k = 0; k < NUM_LANES; k++) begin : g_lane
            demux_lane #(.N(N)) u_lane (
                .clk   (clk),
                .rst   (rst),
                .flush (flush),
                .load  (load[k]),
                .din   (in_data),
                .ready (out_ready[k]),
                .valid (out_valid[k]),
                .dout  (out_data[k])
            );
        end
    endgenerate

endmodule

// File: tb/tb_demux128_reg.sv
// Scoreboard bench for demux128_reg: a per-lane queue model is updated at each
// rising edge, and a monitor on the falling edge compares the DUT against it.
module tb_demux128_reg;
    import demux_pkg::*;

    localparam int N     = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           flush = 1'b0;
    logic [N-1:0]   in_data = '0;
    logic [2:0]     in_sel = '0;
    logic [7:0]     out_ready = '0;
    logic           in_ready;
    logic [N-1:0]   out_data [NUM_LANES-1:0];
    logic [7:0]     out_valid;
    logic [CNT_W-1:0] acc_cnt;

    demux128_reg #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_cnt   (acc_cnt)
    );

    always #5 clk = ~clk;

    // reference model
    logic [N-1:0] lq [8][$];
    logic [N-1:0] last [8];
    int cnt = 0;
    int ptr = 0;
    bit started = 0;
    int tests = 0;
    int errs = 0;

    function automatic int dst();
`ifdef DEMUX_AUTO_SEL_EN
        return ptr;
`else
        return int'(in_sel);
`endif
    endfunction

    function automatic bit exp_rdy();
        int d;
        d = dst();
        return !flush && (lq[d].size() == 0 || out_ready[d]);
    endfunction

    task automatic check(input string name, input int lane, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s lane=%0d got=%0h exp=%0h t=%0t", name, lane, got, exp, $time);
        end
    endtask

    // model update on the active edge, using pre-edge inputs and model state
    always @(posedge clk) begin
        bit x;
        int d;
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                lq[k].delete();
                last[k] = '0;
            end
            cnt = 0;
            ptr = 0;
            started = 1;
        end else begin
            x = in_valid && exp_rdy();
            d = dst();
            for (int k = 0; k < 8; k++)
                if (lq[k].size() != 0 && out_ready[k])
                    void'(lq[k].pop_front());
            if (flush) begin
                for (int k = 0; k < 8; k++) lq[k].delete();
            end else if (x) begin
                lq[d].push_back(in_data);
                last[d] = in_data;
                if (cnt < CMAX) cnt++;
                ptr = (ptr + 1) % 8;
            end
        end
    end

    // monitor: compare DUT outputs against model away from the active edge
    always @(negedge clk) begin
        if (started) begin
            check("in_ready", 0, {31'b0, in_ready}, {31'b0, exp_rdy()});
            check("acc_cnt", 0, 32'(acc_cnt), 32'(cnt));
            for (int k = 0; k < 8; k++) begin
                check("out_valid", k, {31'b0, out_valid[k]}, {31'b0, (lq[k].size() != 0)});
                if (lq[k].size() != 0)
                    check("out_data", k, 32'(out_data[k]), 32'(lq[k][0]));
                else
                    check("held_data", k, 32'(out_data[k]), 32'(last[k]));
            end
        end
    end

    task automatic drive(input bit v, input int sel, input int d, input logic [7:0] rdy, input bit fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_sel    = 3'(sel);
        in_data   = N'(d);
        out_ready = rdy;
        flush     = fl;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // single steer, then a second word to the same full lane is held
        drive(1, 5, 'hA, 8'h00, 0);
        drive(1, 5, 'h7, 8'h00, 0);
        drive(1, 5, 'h7, 8'h20, 0);
        drive(0, 0, 0, 8'hFF, 0);

        // back-to-back into a continuously ready lane
        drive(1, 2, 1, 8'h04, 0);
        drive(1, 2, 2, 8'h04, 0);
        drive(1, 2, 3, 8'h04, 0);
        drive(0, 0, 0, 8'h04, 0);
        drive(0, 0, 0, 8'hFF, 0);

        // independence of lanes 0 and 7
        drive(1, 0, 'h3, 8'h00, 0);
        drive(1, 7, 'hC, 8'h00, 0);
        drive(0, 0, 0, 8'h01, 0);
        drive(0, 0, 0, 8'h00, 0);
        drive(0, 0, 0, 8'hFF, 0);

        // flush with a pending producer word
        drive(1, 1, 5, 8'h00, 0);
        drive(1, 4, 6, 8'h00, 0);
        drive(1, 3, 9, 8'h00, 1);
        drive(0, 0, 0, 8'h00, 0);
        drive(0, 0, 0, 8'hFF, 0);

        // nine words with everything ready (round-robin walk when auto-select is built)
        for (int i = 0; i < 9; i++) drive(1, 0, i, 8'hFF, 0);
        drive(0, 0, 0, 8'hFF, 0);

        // randomized traffic, long enough to saturate the counter
        for (int i = 0; i < 3000; i++)
            drive(($urandom % 4) != 0, int'($urandom % 8), int'($urandom % 16),
                  8'($urandom), ($urandom % 32) == 0);

        drive(0, 0, 0, 8'h00, 0);
        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
